// File: rtl/mux_scan_sequencer.sv
// Purpose: round-robin scan of a 16-input mux over the enabled mask bits, capturing MuxOut per input.
// Latency: Start -> Enable for DwellCycles cycles -> DataValid; one sample every DwellCycles+1 cycles.
// Backpressure: a sample is held stable in OUTPUT until DataValid & DataReady; no new select meanwhile.
module mux_scan_sequencer #(
   parameter int NrOfBits    = 32,
   parameter int DwellCycles = 1
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Start,
   input  logic                Stop,
   input  logic [15:0]         Mask,
   input  logic [NrOfBits-1:0] MuxData,
   output logic [3:0]          Sel,
   output logic                Enable,
   output logic [NrOfBits-1:0] Data,
   output logic [3:0]          DataIdx,
   output logic                DataValid,
   input  logic                DataReady,
   output logic                Busy
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SELECT = 2'd1;
   localparam logic [1:0] OUTPUT = 2'd2;

   localparam logic [3:0] LAST_DWELL = 4'(DwellCycles - 1);

   logic [1:0] state;
   logic [3:0] ptr;
   logic [3:0] dwell_cnt;
   logic [3:0] nxt_idx;
   logic       stop_pending;
   logic       handshake;
   logic       mask_any;

   assign handshake = DataValid & DataReady;
   assign mask_any  = |Mask;
   assign Enable    = (state == SELECT);
   assign Busy      = (state != IDLE);

   // Next index: first set mask bit searching circularly from ptr+1 round to ptr itself.
   // Walking k downwards lets the smallest distance win without a found flag.
   always_comb begin
      nxt_idx = ptr;
      for (int k = 16; k >= 1; k--) begin
         if (Mask[ptr + 4'(k)]) begin
            nxt_idx = ptr + 4'(k);
         end
      end
   end

   // Scan state machine: select/dwell, capture, hold for handshake, then advance or stop.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state        <= IDLE;
         Sel          <= 4'd0;
         Data         <= '0;
         DataIdx      <= 4'd0;
         DataValid    <= 1'b0;
         ptr          <= 4'hF;
         dwell_cnt    <= 4'd0;
         stop_pending <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // An empty mask has nothing to scan, so Start is dropped.
               if (Start && mask_any) begin
                  Sel          <= nxt_idx;
                  dwell_cnt    <= 4'd0;
                  stop_pending <= Stop;
                  state        <= SELECT;
               end
            end
            SELECT: begin
               if (Stop) begin
                  stop_pending <= 1'b1;
               end
               if (dwell_cnt == LAST_DWELL) begin
                  Data      <= MuxData;
                  DataIdx   <= Sel;
                  DataValid <= 1'b1;
                  ptr       <= Sel;
                  state     <= OUTPUT;
               end else begin
                  dwell_cnt <= dwell_cnt + 4'd1;
               end
            end
            OUTPUT: begin
               if (Stop) begin
                  stop_pending <= 1'b1;
               end
               if (handshake) begin
                  DataValid <= 1'b0;
                  // A Stop arriving on the handshake cycle itself also ends the scan.
                  if (stop_pending || Stop || !mask_any) begin
                     stop_pending <= 1'b0;
                     state        <= IDLE;
                  end else begin
                     Sel       <= nxt_idx;
                     dwell_cnt <= 4'd0;
                     state     <= SELECT;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Purpose: self-checking bench for mux_scan_sequencer with one instance at dwell 1 and one at dwell 3.
// Latency: outputs sampled on the falling edge, inputs driven there for the next rising edge.
// Backpressure: DataReady is held high except for a directed stall of five cycles.
module tb_mux_scan_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        stop;
   logic        rdy;
   logic [15:0] mask;
   logic [31:0] mux_in [16];

   logic [3:0]  sel1, idx1, sel3, idx3;
   logic        en1, vld1, busy1, en3, vld3, busy3;
   logic [31:0] data1, data3, mux1, mux3;

   int n_asrt = 0;
   int n_fail = 0;
   int m_ptr  = 15;

   always #5 clk = ~clk;

   // The mux being driven: each instance sees the input its own Sel points at.
   assign mux1 = mux_in[sel1];
   assign mux3 = mux_in[sel3];

   mux_scan_sequencer #(.NrOfBits(32), .DwellCycles(1)) u1 (
      .Clock(clk), .Reset(rst), .Start(start), .Stop(stop), .Mask(mask),
      .MuxData(mux1), .Sel(sel1), .Enable(en1), .Data(data1), .DataIdx(idx1),
      .DataValid(vld1), .DataReady(rdy), .Busy(busy1));

   mux_scan_sequencer #(.NrOfBits(32), .DwellCycles(3)) u3 (
      .Clock(clk), .Reset(rst), .Start(start), .Stop(stop), .Mask(mask),
      .MuxData(mux3), .Sel(sel3), .Enable(en3), .Data(data3), .DataIdx(idx3),
      .DataValid(vld3), .DataReady(rdy), .Busy(busy3));

   // Reference: first enabled input strictly after p, wrapping back to p itself.
   function automatic int m_next(int p, logic [15:0] m);
      for (int k = 1; k <= 16; k++) begin
         if (m[(p + k) % 16]) return (p + k) % 16;
      end
      return -1;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic fill_mux(bit pattern);
      for (int i = 0; i < 16; i++) begin
         mux_in[i] = pattern ? 32'(32'hA0 + i) : $urandom;
      end
   endtask

   task automatic start_pulse(logic with_stop);
      start = 1'b1;
      stop  = with_stop;
      cyc();
      start = 1'b0;
      stop  = 1'b0;
   endtask

   // Called from a negedge in SELECT; with dwell 1 the sample must show one cycle later.
   task automatic expect_sample(int e, string tag);
      int w = 0;
      do begin
         cyc();
         w++;
      end while (!vld1 && w < 20);
      chk({tag, "_lat"}, 64'(w), 64'd1);
      chk({tag, "_vld"}, 64'(vld1), 64'd1);
      chk({tag, "_idx"}, 64'(idx1), 64'(e));
      chk({tag, "_dat"}, 64'(data1), 64'(mux_in[e]));
      chk({tag, "_en"}, 64'(en1), 64'd0);
   endtask

   // Serve 'items' samples from the SELECT position, stopping on the last; optionally mutate the mask.
   task automatic run_scan(int items, bit mutate, string tag);
      int e;
      for (int n = 0; n < items; n++) begin
         e = m_next(m_ptr, mask);
         chk({tag, "_sel"}, 64'(sel1), 64'(e));
         chk({tag, "_selen"}, 64'(en1), 64'd1);
         chk({tag, "_selvld"}, 64'(vld1), 64'd0);
         if (n == items - 1) stop = 1'b1;
         expect_sample(e, tag);
         stop  = 1'b0;
         m_ptr = e;
         if (mutate && n < items - 1 && $urandom_range(0, 1) == 1) begin
            mask = 16'($urandom_range(1, 65535));
         end
         cyc();
      end
      chk({tag, "_idle"}, 64'(busy1), 64'd0);
      chk({tag, "_idlevld"}, 64'(vld1), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int e;
      int low;
      logic [31:0] hold_d;
      logic [3:0]  hold_i;

      rst   = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      mask  = 16'h0000;
      rdy   = 1'b1;
      fill_mux(1'b1);
      cyc();
      cyc();
      rst = 1'b0;

      // Reset state.
      chk("rst_busy", 64'(busy1), 64'd0);
      chk("rst_en", 64'(en1), 64'd0);
      chk("rst_vld", 64'(vld1), 64'd0);
      chk("rst_sel", 64'(sel1), 64'd0);
      chk("rst_idx", 64'(idx1), 64'd0);
      chk("rst_data", 64'(data1), 64'd0);

      // Empty mask: Start is ignored.
      start_pulse(1'b0);
      chk("empty_busy", 64'(busy1), 64'd0);
      chk("empty_en", 64'(en1), 64'd0);
      cyc();
      chk("empty_busy2", 64'(busy1), 64'd0);
      chk("empty_vld", 64'(vld1), 64'd0);

      // Back-to-back scan over 0,5,10,15,0.
      mask = 16'h8421;
      start_pulse(1'b0);
      run_scan(5, 1'b0, "rr");
      chk("rr_ptr", 64'(m_ptr), 64'd0);

      // Start with Stop: a single item, and it repeats on the next single step.
      mask = 16'h0010;
      start_pulse(1'b1);
      run_scan(1, 1'b0, "ss");
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("ss_quiet", 64'(en1), 64'd0);
      end
      start_pulse(1'b1);
      run_scan(1, 1'b0, "ss2");
      chk("ss2_idx", 64'(idx1), 64'd4);

      // Backpressure: sample held for five cycles, then advance right after DataReady rises.
      fill_mux(1'b0);
      mask = 16'($urandom_range(1, 65535));
      rdy  = 1'b0;
      start_pulse(1'b0);
      e = m_next(m_ptr, mask);
      expect_sample(e, "bp");
      hold_d = data1;
      hold_i = idx1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("bp_vld", 64'(vld1), 64'd1);
         chk("bp_dat", 64'(data1), 64'(mux_in[e]));
         chk("bp_idx", 64'(idx1), 64'(e));
         chk("bp_en", 64'(en1), 64'd0);
         chk("bp_busy", 64'(busy1), 64'd1);
      end
      rdy   = 1'b1;
      m_ptr = e;
      cyc();
      chk("bp_adv_vld", 64'(vld1), 64'd0);
      chk("bp_adv_en", 64'(en1), 64'd1);
      chk("bp_adv_sel", 64'(sel1), 64'(m_next(m_ptr, mask)));
      run_scan(1, 1'b0, "bp_end");

      // Mask cleared while input 3 is selected: that sample still arrives, then idle.
      mask = 16'h00FF;
      start_pulse(1'b0);
      e = m_next(m_ptr, mask);
      for (int guard = 0; guard < 10 && e != 3; guard++) begin
         chk("mc_sel", 64'(sel1), 64'(e));
         expect_sample(e, "mc");
         m_ptr = e;
         cyc();
         e = m_next(m_ptr, mask);
      end
      chk("mc_sel3", 64'(sel1), 64'd3);
      chk("mc_en3", 64'(en1), 64'd1);
      mask = 16'h0000;
      expect_sample(3, "mc3");
      m_ptr = 3;
      cyc();
      chk("mc_idle", 64'(busy1), 64'd0);
      chk("mc_vld", 64'(vld1), 64'd0);

      // Randomized scans with random data and masks changing between items.
      for (int r = 0; r < 6; r++) begin
         fill_mux(1'b0);
         mask = 16'($urandom_range(1, 65535));
         start_pulse(1'b0);
         run_scan($urandom_range(1, 5), 1'b1, "rnd");
      end

      // Dwell 3: reset in the second dwell cycle, then a full item from the lowest mask bit.
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      m_ptr = 15;
      chk("d3_rst_busy", 64'(busy3), 64'd0);
      fill_mux(1'b0);
      mask = 16'($urandom_range(1, 65535));
      low  = m_next(15, mask);
      start_pulse(1'b0);
      chk("d3_dw1_en", 64'(en3), 64'd1);
      chk("d3_dw1_sel", 64'(sel3), 64'(low));
      cyc();
      chk("d3_dw2_en", 64'(en3), 64'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("d3_mr_sel", 64'(sel3), 64'd0);
      chk("d3_mr_en", 64'(en3), 64'd0);
      chk("d3_mr_data", 64'(data3), 64'd0);
      chk("d3_mr_idx", 64'(idx3), 64'd0);
      chk("d3_mr_vld", 64'(vld3), 64'd0);
      chk("d3_mr_busy", 64'(busy3), 64'd0);
      start_pulse(1'b0);
      for (int d = 0; d < 3; d++) begin
         chk("d3_dw_en", 64'(en3), 64'd1);
         chk("d3_dw_sel", 64'(sel3), 64'(low));
         chk("d3_dw_vld", 64'(vld3), 64'd0);
         cyc();
      end
      chk("d3_vld", 64'(vld3), 64'd1);
      chk("d3_idx", 64'(idx3), 64'(low));
      chk("d3_dat", 64'(data3), 64'(mux_in[low]));
      chk("d3_en", 64'(en3), 64'd0);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Drives Sel/Enable of a 16-input bus multiplexer (NrOfBits wide) and captures the selected MuxOut value.
- Steps round-robin through the inputs enabled in a 16-bit mask and presents each sample on a valid/ready output port.
- Sits beside the mux in the single-cycle CPU debug/display path: upstream of it as the select source, downstream of it as the consumer of MuxOut.

Parameters:
- NrOfBits, 32, width of the mux data path and of the captured sample.
- DwellCycles, 1, cycles Enable/Sel are held per input before capture; legal range 1..15.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  begin scanning; one-cycle pulse or level.
- Stop  in  1  finish the current item, then return to IDLE.
- Mask  in  16  bit i=1 means input i is part of the scan.
- MuxData  in  NrOfBits  MuxOut of the driven multiplexer.
- Sel  out  4  select to the multiplexer.
- Enable  out  1  enable to the multiplexer.
- Data  out  NrOfBits  captured sample.
- DataIdx  out  4  input index that Data was taken from.
- DataValid  out  1  Data/DataIdx are valid.
- DataReady  in  1  consumer accepts the sample.
- Busy  out  1  state is not IDLE.

Behaviour:
- Reset (synchronous, takes priority over everything, including mid-operation):
  - state=IDLE; Sel=0, Enable=0, Data=0, DataIdx=0, DataValid=0, Busy=0.
  - Pointer ptr=15, so the first search starts at input 0.
  - Dwell counter=0, stop_pending=0.
- Next-index function nxt(p, m): first set bit of m, searching circularly from p+1 (mod 16) through p. With ptr=15 the search order is 0..15.
- IDLE:
  - Enable=0; Sel holds its last value.
  - Start=1 and Mask!=0: idx=nxt(ptr,Mask); Sel=idx; go to SELECT; counter=0; stop_pending=Stop.
  - Start=1 and Mask==0: ignored, stay IDLE.
  - Stop alone: ignored.
  - Start and Stop in the same cycle: single step; exactly one item is served, then IDLE.
- SELECT:
  - Enable=1 and Sel=idx, held for DwellCycles cycles.
  - On the last dwell cycle (counter==DwellCycles-1): Data<=MuxData, DataIdx<=idx, DataValid<=1, ptr<=idx, go to OUTPUT.
  - Enable deasserts in OUTPUT.
- OUTPUT:
  - DataValid=1. Data/DataIdx stay stable until the handshake; Enable=0.
  - Handshake = DataValid & DataReady. On it, DataValid<=0 and:
    - stop_pending=1 or Mask==0: go to IDLE.
    - otherwise: idx=nxt(ptr,Mask), Sel=idx, counter=0, go to SELECT.
- Stop in SELECT or OUTPUT sets stop_pending. The current item is still captured and delivered; stop_pending clears on entry to IDLE.
- Start while not IDLE is ignored.
- Mask is sampled only when the next index is computed (IDLE start, OUTPUT handshake). Changes during an item do not abort it.
- A single-bit mask rescans the same input each round.
- Latency with DwellCycles=D: Start sampled at edge T gives Enable=1 for cycles T+1..T+D and DataValid=1 from cycle T+D+1. Back-to-back throughput is one sample per D+1 cycles with DataReady held high.
- ptr persists across IDLE periods. After Stop, the next Start resumes at the input after the last one served.
- Busy=1 in SELECT and OUTPUT.

Test Plan:
- Reset, Mask=16'h0000, pulse Start -> stays IDLE; Busy=0, Enable=0, DataValid=0.
- Mask=16'h8421, MuxData=0xA0+Sel, D=1, DataReady=1, Start -> DataIdx sequence 0,5,10,15,0 with Data 0xA0,0xA5,0xAA,0xAF,0xA0; DataValid high every 2nd cycle; first DataValid 2 cycles after Start.
- Start and Stop together, Mask=16'h0010 -> exactly one sample, DataIdx=4; then IDLE, Busy=0. A second Start gives DataIdx=4 again.
- DataReady=0 for 5 cycles in OUTPUT -> Data/DataIdx/DataValid stable, Enable=0, no new select. Raise DataReady -> advance occurs the next cycle.
- Mask changed from 16'h00FF to 16'h0000 while in SELECT on idx 3 -> sample from idx 3 is delivered, then IDLE.
- D=3, Reset asserted in the 2nd dwell cycle -> next cycle all outputs zero, IDLE. Start then serves the lowest set mask bit.
